// File: rtl/top_serial_queue_if.sv
// top_serial_queue_if: serial bit/strobe inputs and queue status/data outputs
interface top_serial_queue_if #(parameter int WORD_BITS = 8);
  logic data_in;
  logic write_in;
  logic enqueue_in;
  logic dequeue_in;
  logic status_out;
  logic [WORD_BITS-1:0] data_out;
  modport master(output data_in, write_in, enqueue_in, dequeue_in, input status_out, data_out);
  modport slave(input data_in, write_in, enqueue_in, dequeue_in, output status_out, data_out);
endinterface

// File: rtl/top_serial_queue.sv
// top_serial_queue: MSB-first serial deserializer feeding a word FIFO popped by a strobe
module top_serial_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int WORD_BITS = 8
) (
  input logic clock_1MHz,
  input logic rst,
  top_serial_queue_if.slave bus
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int BW = WORD_BITS > 1 ? $clog2(WORD_BITS) : 1;
  logic [1:0] d_s;
  logic [2:0] w_s, q_s;
  logic [WORD_BITS-1:0] sr, hold_word, dout, next_sr;
  logic [WORD_BITS-1:0] mem [QUEUE_DEPTH];
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic hold, status, take, last, full, enq, deq;
  // third strobe flop only remembers the previous synchronized level for edge detection
  always_comb begin
    next_sr = {sr[WORD_BITS-2:0], d_s[1]};
    last = bit_cnt == BW'(WORD_BITS - 1);
    take = w_s[1] & ~w_s[2] & status & ~hold;
    full = count == CW'(QUEUE_DEPTH);
    enq = hold & ~full;
    deq = q_s[1] & ~q_s[2] & (count != '0);
  end
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      d_s <= '0;
      w_s <= '0;
      q_s <= '0;
      sr <= '0;
      hold_word <= '0;
      bit_cnt <= '0;
      hold <= 1'b0;
      status <= 1'b0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      d_s <= {d_s[0], bus.data_in};
      w_s <= {w_s[1:0], bus.write_in};
      q_s <= {q_s[1:0], bus.dequeue_in};
      if (take) begin
        sr <= last ? '0 : next_sr;
        bit_cnt <= last ? '0 : bit_cnt + BW'(1);
      end
      if (take && last) begin
        hold <= 1'b1;
        hold_word <= next_sr;
      end else if (enq) hold <= 1'b0;
      status <= ~(hold & full);
      if (enq) wr <= wr == PW'(QUEUE_DEPTH - 1) ? '0 : wr + PW'(1);
      if (deq) begin
        dout <= mem[rd];
        rd <= rd == PW'(QUEUE_DEPTH - 1) ? '0 : rd + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clock_1MHz) if (enq) mem[wr] <= hold_word;
  assign bus.status_out = status;
  assign bus.data_out = dout;
endmodule

// File: tb/tb_top_serial_queue.sv
// tb_top_serial_queue: directed and random strobe traffic against a queue-level reference model
`timescale 1ns/1ps
module tb_top_serial_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_rand = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] q [$];
  logic [7:0] cur = '0;
  logic [7:0] pend = '0;
  logic [7:0] exp_d = '0;
  int nbits = 0;
  bit blocked = 1'b0;
  top_serial_queue_if sq();
  top_serial_queue dut(.clock_1MHz(clk), .rst(rst), .bus(sq.slave));
  always #500 clk = ~clk;
  always @(negedge clk) sq.enqueue_in = en_rand ? 1'($urandom) : 1'bx;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    nbits = 0;
    cur = '0;
    blocked = 1'b0;
    exp_d = '0;
  endtask
  task automatic send_bit(input logic b, input int hi, input int lo);
    @(negedge clk);
    sq.data_in = b;
    sq.write_in = 1'b1;
    repeat (hi) @(negedge clk);
    sq.write_in = 1'b0;
    repeat (lo) @(negedge clk);
    if (!blocked) begin
      cur = {cur[6:0], b};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        if (q.size() < 8) q.push_back(cur);
        else begin
          pend = cur;
          blocked = 1'b1;
        end
      end
    end
  endtask
  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int i = 7; i >= 0; i--) send_bit(w[i], hi, lo);
  endtask
  task automatic deq_pulse(input int hi, input int lo);
    @(negedge clk);
    sq.dequeue_in = 1'b1;
    repeat (hi) @(negedge clk);
    sq.dequeue_in = 1'b0;
    repeat (lo) @(negedge clk);
    if (q.size() > 0) begin
      exp_d = q.pop_front();
      if (blocked) begin
        q.push_back(pend);
        blocked = 1'b0;
      end
    end
  endtask
  task automatic check_state(input string tag);
    chk({tag, "_data"}, sq.data_out, exp_d);
    chk({tag, "_status"}, {7'b0, sq.status_out}, {7'b0, !blocked});
  endtask
  task automatic run_four(input string tag);
    for (int w = 0; w < 4; w++) send_word(8'h80 + 8'(w), 10, 10);
    for (int k = 0; k < 4; k++) begin
      deq_pulse(10, 10);
      chk($sformatf("%s_pop%0d", tag, k), sq.data_out, 8'h80 + 8'(k));
    end
    deq_pulse(10, 10);
    chk({tag, "_pop_empty"}, sq.data_out, 8'h83);
  endtask
  initial begin
    sq.data_in = 1'b0;
    sq.write_in = 1'b0;
    sq.dequeue_in = 1'b0;
    #2500;
    chk("reset_status", {7'b0, sq.status_out}, 8'h00);
    chk("reset_data", sq.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_status", {7'b0, sq.status_out}, 8'h01);
    send_word(8'h80, 10, 10);
    deq_pulse(200, 10);
    chk("single_pop", sq.data_out, 8'h80);
    check_state("single");
    deq_pulse(10, 10);
    chk("single_once", sq.data_out, 8'h80);
    run_four("order_x");
    en_rand = 1'b1;
    run_four("order_rand");
    en_rand = 1'b0;
    for (int w = 0; w < 9; w++) send_word(8'(w), 10, 10);
    chk("full_blocked", {7'b0, sq.status_out}, 8'h00);
    deq_pulse(10, 10);
    chk("full_first", sq.data_out, 8'h00);
    chk("full_unblocked", {7'b0, sq.status_out}, 8'h01);
    for (int k = 1; k < 9; k++) begin
      deq_pulse(10, 10);
      chk($sformatf("full_pop%0d", k), sq.data_out, 8'(k));
    end
    for (int i = 0; i < 5; i++) send_bit(1'b1, 10, 10);
    send_word(8'h3C, 10, 10);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midword_rst_data", sq.data_out, 8'h00);
    chk("midword_rst_status", {7'b0, sq.status_out}, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_word(8'hA5, 10, 10);
    deq_pulse(10, 10);
    chk("after_rst_pop", sq.data_out, 8'hA5);
    deq_pulse(10, 10);
    chk("after_rst_empty", sq.data_out, 8'hA5);
    en_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < (n < 30 ? 35 : 60)) deq_pulse(4, 4);
      else send_word(8'($urandom_range(0, 255)), 4, 4);
      check_state($sformatf("rand%0d", n));
    end
    while (q.size() > 0 || blocked) begin
      deq_pulse(4, 4);
      check_state("drain");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
